// File: rtl/bht_update_gen.sv
// bht_update_gen: collects up to two resolved branches per cycle, buffers the
// conditional ones in program order and drains one BHT update per cycle to
// the frontend predictor, which cannot apply backpressure.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   VLEN   branch PC width
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flush_i            squash the queue and the output register
//   debug_mode_i       block enqueue while high; queued entries still drain
//   res_*_i [1:0]      per-port resolutions, port 0 is the older branch
//   res_ready_o        at least two free slots (from the registered count)
//   bht_update_o       registered {valid, pc[VLEN-1:0], taken}
//   overflow_o         pulses the cycle after an eligible entry was dropped
//   stat_cond_o        enqueued conditional branches (saturating)
//   stat_mispred_o     enqueued mispredicted conditional branches (saturating)
// Optional feature: define BHT_UPDATE_STATS_EN to build the statistics
// counters; otherwise both statistics outputs are tied to zero.

module bht_update_gen #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  input  logic [1:0]           res_valid_i,
  input  logic [1:0][VLEN-1:0] res_pc_i,
  input  logic [1:0]           res_taken_i,
  input  logic [1:0]           res_is_cond_i,
  input  logic [1:0]           res_mispredict_i,
  output logic                 res_ready_o,
  output logic [VLEN+1:0]      bht_update_o,
  output logic                 overflow_o,
  output logic [31:0]          stat_cond_o,
  output logic [31:0]          stat_mispred_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [VLEN-1:0] r_pc_mem [DEPTH];
  logic [DEPTH-1:0] r_taken_mem;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_valid;
  logic [VLEN-1:0] r_pc;
  logic            r_taken;
  logic            r_overflow;

  logic [1:0]      w_elig;
  logic            w_deq;
  logic [CW-1:0]   w_free;
  logic            w_enq0;
  logic            w_enq1;
  logic            w_drop;
  logic [1:0]      w_n_enq;
  logic [VLEN-1:0] w_first_pc;
  logic            w_first_taken;
  logic            w_first_mis;

  assign w_elig = res_valid_i & res_is_cond_i & {2{~debug_mode_i & ~flush_i}};
  assign w_deq  = (r_count != '0);
  // Slots available once this cycle's head has been popped.
  assign w_free = DepthC - r_count + {{(CW-1){1'b0}}, w_deq};

  // First written slot takes the oldest eligible port; the second slot is
  // only ever port 1, so when space is short port 1 is the one dropped.
  assign w_enq0  = (|w_elig) && (w_free != '0);
  assign w_enq1  = (&w_elig) && (w_free >= CW'(2));
  assign w_drop  = ((&w_elig) && !w_enq1) || ((|w_elig) && !w_enq0);
  assign w_n_enq = {1'b0, w_enq0} + {1'b0, w_enq1};

  assign w_first_pc    = w_elig[0] ? res_pc_i[0]         : res_pc_i[1];
  assign w_first_taken = w_elig[0] ? res_taken_i[0]      : res_taken_i[1];
  assign w_first_mis   = w_elig[0] ? res_mispredict_i[0] : res_mispredict_i[1];

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_enq0) begin
      r_pc_mem[r_wr_ptr]    <= w_first_pc;
      r_taken_mem[r_wr_ptr] <= w_first_taken;
    end
    if (w_enq1) begin
      r_pc_mem[r_wr_ptr + PW'(1)]    <= res_pc_i[1];
      r_taken_mem[r_wr_ptr + PW'(1)] <= res_taken_i[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_taken    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_deq) begin
        r_valid  <= 1'b1;
        r_pc     <= r_pc_mem[r_rd_ptr];
        r_taken  <= r_taken_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_valid <= 1'b0;
      end
      r_wr_ptr   <= r_wr_ptr + PW'(w_n_enq);
      r_count    <= r_count + CW'(w_n_enq) - CW'(w_deq);
      r_overflow <= w_drop;
    end
  end

  assign res_ready_o  = (DepthC - r_count) >= CW'(2);
  assign bht_update_o = {r_valid, r_pc, r_taken};
  assign overflow_o   = r_overflow;

`ifdef BHT_UPDATE_STATS_EN
  logic [31:0] r_stat_cond;
  logic [31:0] r_stat_mis;
  logic [1:0]  w_n_mis;

  assign w_n_mis = {1'b0, w_enq0 & w_first_mis} + {1'b0, w_enq1 & res_mispredict_i[1]};

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Flush never reaches these: eligibility is already masked by flush_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_cond <= '0;
      r_stat_mis  <= '0;
    end else begin
      r_stat_cond <= sat_add(r_stat_cond, w_n_enq);
      r_stat_mis  <= sat_add(r_stat_mis, w_n_mis);
    end
  end

  assign stat_cond_o    = r_stat_cond;
  assign stat_mispred_o = r_stat_mis;
`else
  logic w_unused_mis;
  assign w_unused_mis   = ^{res_mispredict_i, w_first_mis};
  assign stat_cond_o    = '0;
  assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_bht_update_gen.sv
module tb_bht_update_gen;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned VLEN  = 64;
`ifdef BHT_UPDATE_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 debug = 1'b0;
  logic [1:0]           res_valid = '0;
  logic [1:0][VLEN-1:0] res_pc = '0;
  logic [1:0]           res_taken = '0;
  logic [1:0]           res_cond = '0;
  logic [1:0]           res_mis = '0;
  logic                 ready;
  logic [VLEN+1:0]      upd;
  logic                 ovf;
  logic [31:0]          st_cond;
  logic [31:0]          st_mis;

  bht_update_gen #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .debug_mode_i    (debug),
    .res_valid_i     (res_valid),
    .res_pc_i        (res_pc),
    .res_taken_i     (res_taken),
    .res_is_cond_i   (res_cond),
    .res_mispredict_i(res_mis),
    .res_ready_o     (ready),
    .bht_update_o    (upd),
    .overflow_o      (ovf),
    .stat_cond_o     (st_cond),
    .stat_mispred_o  (st_mis)
  );

  always #5 clk = ~clk;

  wire             u_valid = upd[VLEN+1];
  wire [VLEN-1:0]  u_pc    = upd[VLEN:1];
  wire             u_taken = upd[0];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue; each edge pops the head first, then
  // appends eligible branches oldest-first while there is room.
  typedef struct packed {logic [VLEN-1:0] pc; logic taken;} ent_t;
  ent_t        mq[$];
  logic        m_valid;
  logic [63:0] m_pc;
  logic        m_taken;
  logic        m_ovf;
  longint      m_cond;
  longint      m_mis;

  always @(posedge clk or posedge rst) begin
    bit   drop;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_valid = 1'b0; m_pc = '0; m_taken = 1'b0; m_ovf = 1'b0;
      m_cond = 0; m_mis = 0;
    end else if (flush) begin
      mq.delete();
      m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      drop = 1'b0;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_valid = 1'b1; m_pc = e.pc; m_taken = e.taken;
      end else begin
        m_valid = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (res_valid[k] && res_cond[k] && !debug) begin
          if (mq.size() < DEPTH) begin
            e.pc = res_pc[k]; e.taken = res_taken[k];
            mq.push_back(e);
            m_cond++;
            if (res_mis[k]) m_mis++;
          end else begin
            drop = 1'b1;
          end
        end
      end
      m_ovf = drop;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {63'b0, u_valid}, {63'b0, m_valid});
      if (m_valid) begin
        chk("pc", u_pc, m_pc);
        chk("taken", {63'b0, u_taken}, {63'b0, m_taken});
      end
      chk("overflow", {63'b0, ovf}, {63'b0, m_ovf});
      chk("ready", {63'b0, ready}, {63'b0, ((DEPTH - mq.size()) >= 2)});
      chk("stat_cond", {32'b0, st_cond}, StatsOn ? 64'(m_cond) : 64'd0);
      chk("stat_mis", {32'b0, st_mis}, StatsOn ? 64'(m_mis) : 64'd0);
    end
  end

  task automatic step_in(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                         input logic [1:0] tk, input logic [1:0] cd, input logic [1:0] ms);
    res_valid = v; res_pc[0] = p0; res_pc[1] = p1;
    res_taken = tk; res_cond = cd; res_mis = ms;
    @(negedge clk);
    res_valid = '0; res_taken = '0; res_cond = '0; res_mis = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'b0, u_valid}, 64'd0);
    chk("rst_pc", u_pc, 64'd0);
    chk("rst_ready", {63'b0, ready}, 64'd1);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);
    chk("rst_stat", {32'b0, st_cond}, 64'd0);
    rst = 1'b0;
    idle(2);

    // Single branch: visible only on the cycle after the enqueue edge.
    step_in(2'b01, 64'h8000_0010, 64'h0, 2'b01, 2'b01, 2'b00);
    chk("single_n", {63'b0, u_valid}, 64'd0);
    idle(1);
    chk("single_v", {63'b0, u_valid}, 64'd1);
    chk("single_pc", u_pc, 64'h8000_0010);
    chk("single_tk", {63'b0, u_taken}, 64'd1);
    idle(1);
    chk("single_end", {63'b0, u_valid}, 64'd0);

    // Dual issue drains in program order.
    step_in(2'b11, 64'h100, 64'h104, 2'b10, 2'b11, 2'b00);
    idle(1);
    chk("dual0_pc", u_pc, 64'h100);
    chk("dual0_tk", {63'b0, u_taken}, 64'd0);
    idle(1);
    chk("dual1_pc", u_pc, 64'h104);
    chk("dual1_tk", {63'b0, u_taken}, 64'd1);
    idle(2);

    // Fill until full, then one more dual issue drops port 1.
    step_in(2'b11, 64'h200, 64'h204, 2'b01, 2'b11, 2'b00);
    chk("fill_ready1", {63'b0, ready}, 64'd1);
    step_in(2'b11, 64'h208, 64'h20C, 2'b10, 2'b11, 2'b00);
    chk("fill_ready0", {63'b0, ready}, 64'd0);
    step_in(2'b11, 64'h210, 64'h214, 2'b11, 2'b11, 2'b00);
    chk("fill_noovf", {63'b0, ovf}, 64'd0);
    step_in(2'b11, 64'h218, 64'h21C, 2'b00, 2'b11, 2'b00);
    chk("ovf_pulse", {63'b0, ovf}, 64'd1);
    chk("ovf_pc", u_pc, 64'h208);
    idle(1);
    chk("ovf_clear", {63'b0, ovf}, 64'd0);
    chk("drain0", u_pc, 64'h20C);
    idle(1); chk("drain1", u_pc, 64'h210);
    idle(1); chk("drain2", u_pc, 64'h214);
    idle(1); chk("drain3", u_pc, 64'h218);
    idle(1); chk("drain_end", {63'b0, u_valid}, 64'd0);
    idle(1);

    // Flush with three queued and a new input in the flush cycle.
    step_in(2'b11, 64'h300, 64'h304, 2'b00, 2'b11, 2'b00);
    step_in(2'b11, 64'h308, 64'h30C, 2'b00, 2'b11, 2'b00);
    flush = 1'b1;
    step_in(2'b01, 64'h310, 64'h0, 2'b01, 2'b01, 2'b00);
    flush = 1'b0;
    chk("flush_v", {63'b0, u_valid}, 64'd0);
    chk("flush_ready", {63'b0, ready}, 64'd1);
    idle(1);
    chk("flush_quiet", {63'b0, u_valid}, 64'd0);
    idle(3);

    // Debug mode blocks enqueue but pending entries drain.
    step_in(2'b11, 64'h400, 64'h404, 2'b11, 2'b11, 2'b00);
    debug = 1'b1;
    step_in(2'b01, 64'h408, 64'h0, 2'b01, 2'b01, 2'b00);
    chk("dbg_drain0", u_pc, 64'h400);
    step_in(2'b01, 64'h40C, 64'h0, 2'b01, 2'b01, 2'b00);
    chk("dbg_drain1", u_pc, 64'h404);
    idle(1);
    chk("dbg_blocked", {63'b0, u_valid}, 64'd0);
    debug = 1'b0;
    step_in(2'b01, 64'h500, 64'h0, 2'b01, 2'b00, 2'b00);
    idle(1);
    chk("noncond", {63'b0, u_valid}, 64'd0);

    // Asynchronous reset mid-operation.
    step_in(2'b11, 64'h600, 64'h604, 2'b11, 2'b11, 2'b11);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'b0, u_valid}, 64'd0);
    chk("arst_pc", u_pc, 64'd0);
    chk("arst_ready", {63'b0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Statistics: 10 enqueued conditionals, 3 mispredicted.
    step_in(2'b11, 64'h700, 64'h704, 2'b00, 2'b11, 2'b01); idle(1);
    step_in(2'b11, 64'h708, 64'h70C, 2'b01, 2'b11, 2'b10); idle(1);
    step_in(2'b11, 64'h710, 64'h714, 2'b10, 2'b11, 2'b00); idle(1);
    step_in(2'b11, 64'h718, 64'h71C, 2'b11, 2'b11, 2'b01); idle(1);
    step_in(2'b01, 64'h720, 64'h0, 2'b01, 2'b01, 2'b00);
    step_in(2'b10, 64'h0, 64'h724, 2'b10, 2'b10, 2'b00);
    step_in(2'b01, 64'h728, 64'h0, 2'b00, 2'b00, 2'b01);
    debug = 1'b1;
    step_in(2'b01, 64'h72C, 64'h0, 2'b00, 2'b01, 2'b01);
    debug = 1'b0;
    idle(4);
    chk("stat_cond10", {32'b0, st_cond}, StatsOn ? 64'd10 : 64'd0);
    chk("stat_mis3", {32'b0, st_mis}, StatsOn ? 64'd3 : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
